// File: rtl/atomrvcore_iccm_loader_if.sv
// Byte-stream and ICCM write-port bundle for atomrvcore_iccm_loader.
// The loader connects through the slave modport. The byte source and ICCM side
// (a testbench or the boot-ROM glue) connect through the master modport.
interface atomrvcore_iccm_loader_if #(
  parameter int DATAWIDTH = 32
);
  logic [7:0]           byte_i;
  logic                 byte_valid_i;
  logic                 byte_ready_o;
  logic                 IWR_EN_o;
  logic [DATAWIDTH-1:0] address_o;
  logic [DATAWIDTH-1:0] DATA_o;

  modport slave (
    input  byte_i,
    input  byte_valid_i,
    output byte_ready_o,
    output IWR_EN_o,
    output address_o,
    output DATA_o
  );

  modport master (
    output byte_i,
    output byte_valid_i,
    input  byte_ready_o,
    input  IWR_EN_o,
    input  address_o,
    input  DATA_o
  );
endinterface

// File: rtl/atomrvcore_iccm_loader.sv
// atomrvcore_iccm_loader: packs a little-endian byte stream into 32-bit words
// and writes them to consecutive ICCM addresses. The core is held in reset
// (PCrst_o) until the whole image has been written.
// Optional feature macro: ICCM_LOADER_CHECKSUM_EN. When it is defined, one
// extra word follows the image. That word must equal the 32-bit wrap-around
// sum of the image words, or the loader flags err_o and keeps the core in reset.
module atomrvcore_iccm_loader #(
  parameter int DATAWIDTH  = 32,
  parameter int WCNT_WIDTH = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [WCNT_WIDTH-1:0]   len_i,
  atomrvcore_iccm_loader_if.slave bus,
  output logic                    PCrst_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;

  logic [31:0]             word_r;
  logic [31:0]             assembled_s;
  logic [1:0]              byte_cnt_r;
  logic [WCNT_WIDTH-1:0]   idx_r;
  logic [WCNT_WIDTH-1:0]   idx_inc_s;
  logic [WCNT_WIDTH-1:0]   len_r;

  logic                    accept_s;
  logic                    last_byte_s;
  logic                    load_start_s;

  logic                    byte_ready_r;
  logic                    iwr_en_r;
  logic [DATAWIDTH-1:0]    address_r;
  logic [DATAWIDTH-1:0]    data_r;
  logic                    pcrst_r;
  logic                    busy_r;
  logic                    done_r;

`ifdef ICCM_LOADER_CHECKSUM_EN
  logic [31:0]             sum_r;
  logic                    ck_phase_r;
  logic                    ck_fail_s;
  logic                    err_r;

  // 32-bit wrap-around accumulation of one image word
  function automatic logic [31:0] csum_add(input logic [31:0] sum, input logic [31:0] word);
    return sum + word;
  endfunction
`endif

  assign accept_s    = bus.byte_valid_i & byte_ready_r;
  assign last_byte_s = accept_s & (byte_cnt_r == 2'd3);
  assign idx_inc_s   = idx_r + {{(WCNT_WIDTH-1){1'b0}}, 1'b1};

  // Merge the incoming byte into its little-endian lane of the word being built
  always_comb begin
    assembled_s = word_r;
    case (byte_cnt_r)
      2'd0:    assembled_s[7:0]   = bus.byte_i;
      2'd1:    assembled_s[15:8]  = bus.byte_i;
      2'd2:    assembled_s[23:16] = bus.byte_i;
      2'd3:    assembled_s[31:24] = bus.byte_i;
      default: assembled_s        = word_r;
    endcase
  end

  // Next-state decode: start handling, word completion and the end-of-image decision
  always_comb begin
    state_next_s = state_r;
    load_start_s = 1'b0;
`ifdef ICCM_LOADER_CHECKSUM_EN
    ck_fail_s    = 1'b0;
`endif
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          load_start_s = 1'b1;
          if (len_i != {WCNT_WIDTH{1'b0}}) begin
            state_next_s = ST_COLLECT;
          end else begin
`ifdef ICCM_LOADER_CHECKSUM_EN
            // An empty image still carries a checksum word, and that word must be zero
            state_next_s = ST_COLLECT;
`else
            state_next_s = ST_DONE;
`endif
          end
        end else begin
          state_next_s = state_r;
        end
      end
      ST_COLLECT: begin
        if (last_byte_s) begin
`ifdef ICCM_LOADER_CHECKSUM_EN
          if (ck_phase_r) begin
            if (assembled_s == sum_r) begin
              state_next_s = ST_DONE;
            end else begin
              state_next_s = ST_IDLE;
              ck_fail_s    = 1'b1;
            end
          end else begin
            state_next_s = ST_WRITE;
          end
`else
          state_next_s = ST_WRITE;
`endif
        end else begin
          state_next_s = ST_COLLECT;
        end
      end
      ST_WRITE: begin
        if (idx_inc_s == len_r) begin
`ifdef ICCM_LOADER_CHECKSUM_EN
          state_next_s = ST_COLLECT;
`else
          state_next_s = ST_DONE;
`endif
        end else begin
          state_next_s = ST_COLLECT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Word assembly, byte lane counter, word index and latched length
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_r     <= 32'd0;
      byte_cnt_r <= 2'd0;
      idx_r      <= {WCNT_WIDTH{1'b0}};
      len_r      <= {WCNT_WIDTH{1'b0}};
    end else if (load_start_s) begin
      byte_cnt_r <= 2'd0;
      idx_r      <= {WCNT_WIDTH{1'b0}};
      len_r      <= len_i;
    end else begin
      if (accept_s) begin
        word_r     <= assembled_s;
        byte_cnt_r <= byte_cnt_r + 2'd1;
      end
      if (state_r == ST_WRITE) begin
        idx_r <= idx_inc_s;
      end
    end
  end

`ifdef ICCM_LOADER_CHECKSUM_EN
  // Running checksum, checksum-word phase flag and sticky error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_r      <= 32'd0;
      ck_phase_r <= 1'b0;
      err_r      <= 1'b0;
    end else if (load_start_s) begin
      sum_r      <= 32'd0;
      ck_phase_r <= (len_i == {WCNT_WIDTH{1'b0}});
      err_r      <= 1'b0;
    end else begin
      if (state_r == ST_WRITE) begin
        sum_r <= csum_add(sum_r, word_r);
        if (idx_inc_s == len_r) begin
          ck_phase_r <= 1'b1;
        end
      end
      if (ck_fail_s) begin
        err_r <= 1'b1;
      end
    end
  end
`endif

  // Registered outputs decoded from the next state; address/data only move on a write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byte_ready_r <= 1'b0;
      iwr_en_r     <= 1'b0;
      address_r    <= {DATAWIDTH{1'b0}};
      data_r       <= {DATAWIDTH{1'b0}};
      pcrst_r      <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      byte_ready_r <= (state_next_s == ST_COLLECT);
      iwr_en_r     <= (state_next_s == ST_WRITE);
      pcrst_r      <= (state_next_s != ST_DONE);
      busy_r       <= (state_next_s == ST_COLLECT) || (state_next_s == ST_WRITE);
      done_r       <= (state_next_s == ST_DONE);
      if (state_next_s == ST_WRITE) begin
        address_r <= DATAWIDTH'({idx_r, 2'b00});
        data_r    <= DATAWIDTH'(assembled_s);
      end
    end
  end

  assign bus.byte_ready_o = byte_ready_r;
  assign bus.IWR_EN_o     = iwr_en_r;
  assign bus.address_o    = address_r;
  assign bus.DATA_o       = data_r;
  assign PCrst_o          = pcrst_r;
  assign busy_o           = busy_r;
  assign done_o           = done_r;
`ifdef ICCM_LOADER_CHECKSUM_EN
  assign err_o            = err_r;
`else
  assign err_o            = 1'b0;
`endif

endmodule

// File: tb/tb_atomrvcore_iccm_loader.sv
// Directed bench for atomrvcore_iccm_loader. Stimulus pushes each expected
// ICCM write {address, data} into a queue. A negedge monitor pops the queue and
// compares the entry on every IWR_EN_o cycle. Status outputs are checked inline.
module tb_atomrvcore_iccm_loader;
  localparam int DW = 32;
  localparam int WW = 10;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [WW-1:0] len_i;
  logic          PCrst_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  atomrvcore_iccm_loader_if #(.DATAWIDTH(DW)) bus ();

  atomrvcore_iccm_loader #(.DATAWIDTH(DW), .WCNT_WIDTH(WW)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .start_i (start_i),
    .len_i   (len_i),
    .bus     (bus),
    .PCrst_o (PCrst_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          passed   = 0;
  int          wr_count = 0;
  logic [63:0] exp_q[$];
  logic [31:0] bsum;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: each write cycle must match the oldest expected write
  always @(negedge clk) begin
    if (bus.IWR_EN_o === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                 bus.address_o, bus.DATA_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write_addr", {32'd0, bus.address_o}, {32'd0, e[63:32]});
        check("write_data", {32'd0, bus.DATA_o}, {32'd0, e[31:0]});
      end
    end
  end

  // Offer one byte; returns on the negedge after the accepting posedge
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.byte_i       = b;
    bus.byte_valid_i = 1'b1;
    while (bus.byte_ready_o !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      $display("FAIL byte_ready_timeout: byte 0x%0h never accepted, required acceptance", b);
    end
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] a, input int gap);
    exp_q.push_back({a, w});
    bsum = bsum + w;
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (k == 1 && gap > 0) begin
        repeat (gap) @(negedge clk);
        check("gap_byte_ready", {63'd0, bus.byte_ready_o}, 64'd1);
        check("gap_busy", {63'd0, busy_o}, 64'd1);
      end
    end
  endtask

  task automatic send_raw_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic send_checksum;
`ifdef ICCM_LOADER_CHECKSUM_EN
    send_raw_word(bsum);
`endif
  endtask

  task automatic start_load(input logic [WW-1:0] n);
    start_i = 1'b1;
    len_i   = n;
    bsum    = 32'd0;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_o !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check(name, {63'd0, done_o}, 64'd1);
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int w0;
    rst_i            = 1'b1;
    start_i          = 1'b0;
    len_i            = '0;
    bus.byte_i       = 8'h00;
    bus.byte_valid_i = 1'b0;
    bsum             = 32'd0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_iwr_en", {63'd0, bus.IWR_EN_o}, 64'd0);
    check("rst_address", {32'd0, bus.address_o}, 64'd0);
    check("rst_data", {32'd0, bus.DATA_o}, 64'd0);
    check("rst_pcrst", {63'd0, PCrst_o}, 64'd1);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_err", {63'd0, err_o}, 64'd0);
    check("rst_byte_ready", {63'd0, bus.byte_ready_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Two-word image, little-endian bytes
    start_load(10'd2);
    check("a_busy", {63'd0, busy_o}, 64'd1);
    send_word(32'h12345678, 32'h0, 0);
    send_word(32'hDEADBEEF, 32'h4, 0);
    send_checksum();
    wait_done("a_done");
    check("a_pcrst", {63'd0, PCrst_o}, 64'd0);
    check("a_busy_end", {63'd0, busy_o}, 64'd0);
    check("a_err", {63'd0, err_o}, 64'd0);
    check("a_queue_empty", 64'(exp_q.size()), 64'd0);

    // Restart from DONE reasserts the core reset on the next cycle
    start_load(10'd1);
    check("restart_pcrst", {63'd0, PCrst_o}, 64'd1);
    check("restart_busy", {63'd0, busy_o}, 64'd1);
    check("restart_done", {63'd0, done_o}, 64'd0);
    send_word(32'h0BADC0DE, 32'h0, 0);
    send_checksum();
    wait_done("restart_done_end");

    // Zero-length load
    do_reset();
    w0 = wr_count;
    start_load(10'd0);
`ifndef ICCM_LOADER_CHECKSUM_EN
    check("len0_done_next", {63'd0, done_o}, 64'd1);
    check("len0_pcrst", {63'd0, PCrst_o}, 64'd0);
`else
    send_checksum();
    wait_done("len0_done");
`endif
    check("len0_no_write", 64'(wr_count - w0), 64'd0);

    // Five-cycle gap in byte_valid after byte 2
    start_load(10'd1);
    send_word(32'hCAFEF00D, 32'h0, 5);
    send_checksum();
    wait_done("gap_done");

    // Reset during the 3rd byte of the second word
    start_load(10'd3);
    send_word(32'h03020100, 32'h0, 0);
    send_byte(8'h10);
    send_byte(8'h11);
    bus.byte_i       = 8'h12;
    bus.byte_valid_i = 1'b1;
    rst_i            = 1'b1;
    @(negedge clk);
    rst_i            = 1'b0;
    bus.byte_valid_i = 1'b0;
    check("midrst_pcrst", {63'd0, PCrst_o}, 64'd1);
    check("midrst_busy", {63'd0, busy_o}, 64'd0);
    check("midrst_ready", {63'd0, bus.byte_ready_o}, 64'd0);
    check("midrst_address", {32'd0, bus.address_o}, 64'd0);
    w0 = wr_count;
    repeat (5) @(negedge clk);
    check("midrst_no_write", 64'(wr_count - w0), 64'd0);
    start_load(10'd1);
    send_word(32'hA5A5A5A5, 32'h0, 0);
    send_checksum();
    wait_done("midrst_reload_done");

    // start_i during COLLECT is ignored
    start_load(10'd2);
    exp_q.push_back({32'h0, 32'h44332211});
    bsum = bsum + 32'h44332211;
    send_byte(8'h11);
    send_byte(8'h22);
    start_i = 1'b1;
    len_i   = 10'd7;
    @(negedge clk);
    start_i = 1'b0;
    check("ign_start_busy", {63'd0, busy_o}, 64'd1);
    send_byte(8'h33);
    send_byte(8'h44);
    send_word(32'h88776655, 32'h4, 0);
    send_checksum();
    wait_done("ign_start_done");

    // Maximum length: 2^WW-1 words, index must not wrap
    w0 = wr_count;
    start_load(10'h3FF);
    for (int i = 0; i < 1023; i++) begin
      logic [31:0] pat;
      logic [31:0] adr;
      pat = {16'h5A5A ^ 16'(i), 16'(i)};
      adr = 32'(i) * 32'd4;
      send_word(pat, adr, 0);
    end
    send_checksum();
    wait_done("max_len_done");
    check("max_len_writes", 64'(wr_count - w0), 64'd1023);

`ifdef ICCM_LOADER_CHECKSUM_EN
    // Checksum mismatch, then match
    start_load(10'd1);
    send_word(32'h00000001, 32'h0, 0);
    send_raw_word(32'h00000002);
    repeat (2) @(negedge clk);
    check("ck_bad_err", {63'd0, err_o}, 64'd1);
    check("ck_bad_pcrst", {63'd0, PCrst_o}, 64'd1);
    check("ck_bad_done", {63'd0, done_o}, 64'd0);
    start_load(10'd1);
    check("ck_err_cleared", {63'd0, err_o}, 64'd0);
    send_word(32'h00000001, 32'h0, 0);
    send_raw_word(32'h00000001);
    wait_done("ck_good_done");
    check("ck_good_err", {63'd0, err_o}, 64'd0);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/atomrvcore_iccm_loader.md
ATOMRVCORE_ICCM_LOADER -- requirements
Module: atomrvcore_iccm_loader

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 32, giving the ICCM word and address width.
REQ-002 The block SHALL have parameter WCNT_WIDTH, default 10, giving the width of the word-count input.
REQ-003 The block SHALL use one clock, clk_i, and a synchronous, active-high reset, rst_i.
REQ-004 Port clk_i, input, 1 bit: clock; all state SHALL update on the rising edge.
REQ-005 Port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 Port start_i, input, 1 bit: one-cycle pulse that begins a load.
REQ-007 Port len_i, input, WCNT_WIDTH bits: number of 32-bit words to load, sampled on start_i.
REQ-008 Port byte_i, input, 8 bits: incoming program byte.
REQ-009 Port byte_valid_i, input, 1 bit: byte_i is valid.
REQ-010 Port byte_ready_o, output, 1 bit: loader accepts byte_i.
REQ-011 Port IWR_EN_o, output, 1 bit: ICCM write enable.
REQ-012 Port address_o, output, DATAWIDTH bits: ICCM byte address.
REQ-013 Port DATA_o, output, DATAWIDTH bits: ICCM write data.
REQ-014 Port PCrst_o, output, 1 bit: core/PC reset hold, high while not loaded.
REQ-015 Port busy_o, output, 1 bit: load in progress.
REQ-016 Port done_o, output, 1 bit: load complete, core released.
REQ-017 Port err_o, output, 1 bit: checksum failure (see Configuration).

Function
REQ-018 The FSM SHALL have four states: IDLE, COLLECT, WRITE and DONE.
REQ-019 IDLE: start_i with len_i!=0 -> COLLECT, clearing the word index and byte count; start_i with len_i==0 -> DONE.
REQ-020 A byte SHALL transfer only when byte_valid_i and byte_ready_o are both high; byte_ready_o SHALL be high only in COLLECT.
REQ-021 Bytes SHALL assemble little-endian: the first byte goes to [7:0] and the fourth to [31:24].
REQ-022 When the 4th byte is accepted the FSM SHALL go to WRITE; WRITE SHALL last exactly one cycle, with IWR_EN_o=1, DATA_o=the assembled word and address_o=4*word index.
REQ-023 After WRITE the word index SHALL increment; if it equals the latched length -> DONE, otherwise -> COLLECT.
REQ-024 IWR_EN_o SHALL be 0 in every state other than WRITE; address_o and DATA_o SHALL hold their last values outside WRITE.
REQ-025 PCrst_o SHALL be 1 in IDLE, COLLECT and WRITE, and 0 only in DONE; done_o=(state==DONE); busy_o=(state is COLLECT or WRITE).
REQ-026 start_i SHALL be ignored in COLLECT and WRITE.
REQ-027 In DONE, start_i SHALL restart a load exactly as from IDLE, reasserting PCrst_o on the next cycle.
REQ-028 Gaps in byte_valid_i SHALL stall the load with no timeout and no loss of partial bytes.
REQ-029 The word index SHALL be WCNT_WIDTH bits; len_i of all ones SHALL load 2^WCNT_WIDTH-1 words without wrapping.

Reset
REQ-030 rst_i SHALL force IDLE on the next edge, regardless of state, including mid-word and mid-WRITE.
REQ-031 Reset values SHALL be: IWR_EN_o=0, address_o=0, DATA_o=0, PCrst_o=1, busy_o=0, done_o=0, err_o=0, byte_ready_o=0; index, byte count and checksum SHALL also clear to 0.

Configuration
REQ-032 Macro ICCM_LOADER_CHECKSUM_EN SHALL control the optional checksum check.
REQ-033 With ICCM_LOADER_CHECKSUM_EN defined: the loader SHALL keep a running 32-bit wrap-around sum of the written words.
REQ-034 With ICCM_LOADER_CHECKSUM_EN defined: after the last word it SHALL collect one extra 4-byte word (little-endian) that is not written to the ICCM.
REQ-035 With ICCM_LOADER_CHECKSUM_EN defined: if the extra word matches the sum -> DONE; on mismatch err_o=1, PCrst_o stays 1 and the FSM returns to IDLE, with err_o holding until the next start_i.
REQ-036 With ICCM_LOADER_CHECKSUM_EN defined: for len_i=0 the checksum word SHALL still be collected and compared against 0.
REQ-037 Without ICCM_LOADER_CHECKSUM_EN: err_o SHALL be tied to 0 and no checksum logic SHALL exist.

Verification
REQ-038 Reset, then start_i with len_i=2 and bytes 78 56 34 12 EF BE AD DE -> writes 0x12345678@0x0 and 0xDEADBEEF@0x4, one IWR_EN_o cycle each, then PCrst_o=0 and done_o=1.
REQ-039 start_i with len_i=0 (checksum off) -> DONE on the next cycle with no IWR_EN_o pulse.
REQ-040 Deassert byte_valid_i for 5 cycles after byte 2 of a word -> the same word and address are written once valid resumes.
REQ-041 Assert rst_i during the 3rd byte of word 1 -> IDLE with PCrst_o=1 and no further writes; a new load then starts at address 0.
REQ-042 Checksum on: len_i=1, word 0x00000001, checksum 0x00000002 -> err_o=1, PCrst_o=1; repeating with checksum 0x00000001 -> done_o=1, err_o=0.
REQ-043 Pulse start_i during COLLECT -> ignored; the index and address sequence are unchanged.
